uart_tx_scheduler: RTL and testbench

- Shares the single uart_tx transmitter among N_PORTS byte-stream requesters.
- Arbitration is message-atomic round-robin: a grant is held until the byte flagged last is accepted.
- Configures uart_tx parity per grant from per-port settings, and changes it only while the transmitter is idle.
- Sits between the application byte sources and uart_tx. uart_tx runs off baud_gen oversample_tick; this block has no tick input.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rr_pick.sv | 34 +++
 rtl/uart_tx_scheduler.sv | 143 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit scheduler and its arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONFIG = 2'd1,
    STREAM = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic en;
    logic odd;
  } parity_cfg_t;

  localparam parity_cfg_t PARITY_NONE = parity_cfg_t'(2'b00);

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority picker: the first requester after last_gnt wins.
module uart_rr_pick #(
  parameter int N_PORTS = 4,
  parameter int PTR_W   = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [PTR_W-1:0]   last_gnt,
  output logic [N_PORTS-1:0] gnt_onehot,
  output logic [PTR_W-1:0]   gnt_idx,
  output logic               any
);

  int               scan;
  logic [PTR_W-1:0] cand;

  // Walk the ports in wrap-around order starting just after last_gnt.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    scan       = 0;
    cand       = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      scan = (int'(last_gnt) + k) % N_PORTS;
      cand = PTR_W'(scan);
      if (!any && req[cand]) begin
        any              = 1'b1;
        gnt_idx          = cand;
        gnt_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Message-atomic round-robin scheduler sharing one uart_tx among N_PORTS
// byte-stream requesters; reprograms transmitter parity only while it is idle.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_PORTS        = 4,
  parameter int TIMEOUT_CYCLES = 16384,
  parameter int PTR_W          = $clog2(N_PORTS),
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_PORTS-1:0]   req_valid,
  output logic [N_PORTS-1:0]   req_ready,
  input  logic [8*N_PORTS-1:0] req_data,
  input  logic [N_PORTS-1:0]   req_last,
  input  logic [N_PORTS-1:0]   port_parity_en,
  input  logic [N_PORTS-1:0]   port_parity_odd,
  output logic                 tx_in_valid,
  input  logic                 tx_in_ready,
  output logic [7:0]           tx_in_data,
  output logic                 tx_parity_en,
  output logic                 tx_parity_odd,
  input  logic                 tx_busy,
  output logic [N_PORTS-1:0]   grant,
  output logic                 timeout_pulse,
  output logic [PTR_W-1:0]     timeout_port
);

  sched_state_e       state_q, state_d;
  logic [N_PORTS-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   sel_q, sel_d;
  logic [PTR_W-1:0]   last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  parity_cfg_t        par_q, par_d;
  parity_cfg_t        sel_cfg;
  logic [PTR_W-1:0]   tport_q, tport_d;
  logic               hs;

  logic [N_PORTS-1:0] pick_onehot;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;

  uart_rr_pick #(
    .N_PORTS (N_PORTS),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req        (req_valid),
    .last_gnt   (last_gnt_q),
    .gnt_onehot (pick_onehot),
    .gnt_idx    (pick_idx),
    .any        (pick_any)
  );

  assign sel_cfg       = '{en: port_parity_en[sel_q], odd: port_parity_odd[sel_q]};
  assign grant         = grant_q;
  assign tx_parity_en  = par_q.en;
  assign tx_parity_odd = par_q.odd;
  assign timeout_port  = tport_q;

  // State and control registers; reset returns priority to port 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      sel_q      <= '0;
      last_gnt_q <= PTR_W'(N_PORTS - 1);
      cnt_q      <= '0;
      par_q      <= PARITY_NONE;
      tport_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      par_q      <= par_d;
      tport_q    <= tport_d;
    end
  end

  // Next-state logic and the zero-latency pass-through of the granted port.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    sel_d         = sel_q;
    last_gnt_d    = last_gnt_q;
    cnt_d         = cnt_q;
    par_d         = par_q;
    tport_d       = tport_q;
    tx_in_valid   = 1'b0;
    tx_in_data    = '0;
    req_ready     = '0;
    timeout_pulse = 1'b0;
    hs            = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_onehot;
          sel_d   = pick_idx;
          state_d = CONFIG;
        end
      end
      CONFIG: begin
        // Matching parity costs one cycle; otherwise wait for the line to go quiet.
        if (sel_cfg == par_q) begin
          state_d = STREAM;
        end else if (!tx_busy) begin
          par_d   = sel_cfg;
          state_d = STREAM;
        end
      end
      STREAM: begin
        tx_in_valid = req_valid[sel_q];
        tx_in_data  = req_data[{sel_q, 3'b000} +: 8];
        req_ready   = grant_q & {N_PORTS{tx_in_ready}};
        hs          = req_valid[sel_q] & tx_in_ready;
        if (hs) begin
          cnt_d = '0;
          if (req_last[sel_q]) begin
            last_gnt_d = sel_q;
            grant_d    = '0;
            state_d    = IDLE;
          end
        end else if (!req_valid[sel_q]) begin
          // A requester that goes silent mid-message loses the transmitter.
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_pulse = 1'b1;
            tport_d       = sel_q;
            last_gnt_d    = sel_q;
            grant_d       = '0;
            cnt_d         = '0;
            state_d       = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: a behavioural uart_tx sink, per-port
// message queues and a round-robin message-order model.
module tb_uart_tx_scheduler;

  localparam int N  = 4;
  localparam int TO = 64;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid, req_ready, req_last, pen, podd, grant;
  logic [8*N-1:0] req_data;
  logic           tx_in_valid, tx_in_ready, tx_parity_en, tx_parity_odd, tx_busy;
  logic           timeout_pulse;
  logic [7:0]     tx_in_data;
  logic [1:0]     timeout_port;

  uart_tx_scheduler #(.N_PORTS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_data        (req_data),
    .req_last        (req_last),
    .port_parity_en  (pen),
    .port_parity_odd (podd),
    .tx_in_valid     (tx_in_valid),
    .tx_in_ready     (tx_in_ready),
    .tx_in_data      (tx_in_data),
    .tx_parity_en    (tx_parity_en),
    .tx_parity_odd   (tx_parity_odd),
    .tx_busy         (tx_busy),
    .grant           (grant),
    .timeout_pulse   (timeout_pulse),
    .timeout_port    (timeout_port)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] port;
    logic [1:0] cfg;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] pq[N][$];
  int         gap[N];
  int         sink_cnt;
  int         n_checks = 0;
  int         n_err = 0;
  int         tp_count = 0;
  int         bytes_seen = 0;
  int         m_last;
  logic [1:0] prev_par;
  logic       prev_busy;
  logic       tp_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      req_valid[p]        = (pq[p].size() != 0) && (gap[p] == 0);
      req_data[8*p +: 8]  = (pq[p].size() != 0) ? pq[p][0][7:0] : 8'h00;
      req_last[p]         = (pq[p].size() != 0) ? pq[p][0][8] : 1'b0;
    end
    tx_in_ready = (sink_cnt == 0);
    tx_busy     = (sink_cnt != 0);
  endtask

  task automatic add_byte(input int p, input logic [7:0] d, input logic l);
    pq[p].push_back({l, d});
  endtask

  function automatic bit pending();
    for (int p = 0; p < N; p++) if (pq[p].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Reference order: whole messages, round-robin from the port after the last served.
  task automatic build_expected();
    logic [8:0] cp[N][$];
    logic [8:0] b;
    int         q;
    bit         found;
    for (int p = 0; p < N; p++) cp[p] = pq[p];
    while (1) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        q = (m_last + k) % N;
        if (!found && cp[q].size() != 0) begin
          found = 1'b1;
          do begin
            b = cp[q].pop_front();
            exp_q.push_back('{port: 2'(q), cfg: {pen[q], podd[q]}, data: b[7:0]});
          end while (!b[8] && cp[q].size() != 0);
          m_last = q;
        end
      end
      if (!found) break;
    end
  endtask

  // One clock: observe mid-cycle, then update requesters and the sink model after the edge.
  task automatic step();
    exp_t       e;
    logic [N-1:0] hs_vec;
    logic       tx_hs;
    logic [8:0] b;
    @(negedge clk);
    hs_vec  = req_valid & req_ready;
    tx_hs   = tx_in_valid & tx_in_ready;
    tp_seen = timeout_pulse;
    if (timeout_pulse) tp_count++;
    if ({tx_parity_en, tx_parity_odd} != prev_par) check("parity_change_while_busy", prev_busy, 0);
    prev_par  = {tx_parity_en, tx_parity_odd};
    prev_busy = tx_busy;
    if (tx_hs) begin
      bytes_seen++;
      check("byte_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("tx_data", tx_in_data, e.data);
        check("tx_parity", {tx_parity_en, tx_parity_odd}, e.cfg);
        check("req_ready_vec", hs_vec, 4'b0001 << e.port);
      end
    end else if (hs_vec != 0) begin
      check("spurious_req_ready", hs_vec, 0);
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) begin
      if (hs_vec[p] && pq[p].size() != 0) begin
        b = pq[p].pop_front();
        if (!b[8] && pq[p].size() != 0) gap[p] = $urandom_range(0, 3);
      end else if (gap[p] > 0) begin
        gap[p]--;
      end
    end
    if (tx_hs) sink_cnt = $urandom_range(1, 6);
    else if (sink_cnt > 0) sink_cnt--;
    drive();
  endtask

  task automatic run_drain(input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || pending()) && c < budget) begin
      step();
      c++;
    end
    check("drained_within_budget", c < budget, 1);
    repeat (3) step();
    check("grant_back_to_idle", grant, 0);
  endtask

  task automatic wait_bytes(input int target, input int budget);
    int c = 0;
    while (bytes_seen < target && c < budget) begin
      step();
      c++;
    end
    check("byte_within_budget", bytes_seen >= target, 1);
  endtask

  initial begin
    int nm, len;
    reset_n  = 1'b0;
    pen      = '0;
    podd     = '0;
    sink_cnt = 0;
    m_last   = N - 1;
    for (int p = 0; p < N; p++) gap[p] = 0;
    drive();
    prev_par  = 2'b00;
    prev_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_grant", grant, 0);
    check("reset_req_ready", req_ready, 0);
    check("reset_tx_in_valid", tx_in_valid, 0);
    check("reset_parity", {tx_parity_en, tx_parity_odd}, 0);
    check("reset_timeout_pulse", timeout_pulse, 0);
    check("reset_timeout_port", timeout_port, 0);
    reset_n = 1'b1;

    // Ports 0,1,2 with 3-byte messages at once, port 0 has a second message.
    for (int p = 0; p < 3; p++) begin
      pen[p]  = 1'($urandom_range(0, 1));
      podd[p] = 1'($urandom_range(0, 1));
      for (int i = 0; i < 3; i++) add_byte(p, 8'(8'h10 * (p + 1) + i), i == 2);
    end
    for (int i = 0; i < 3; i++) add_byte(0, 8'(8'h80 + i), i == 2);
    build_expected();
    drive();
    run_drain(500);

    // "HI" on port 0 with even parity.
    pen = '0; podd = '0;
    pen[0] = 1'b1;
    add_byte(0, 8'h48, 1'b0);
    add_byte(0, 8'h49, 1'b1);
    build_expected();
    drive();
    run_drain(200);

    // Port 1 odd parity and port 2 no parity, back to back.
    pen = 4'b0010; podd = 4'b0010;
    for (int m = 0; m < 2; m++) begin
      add_byte(1, 8'(8'hA0 + m), 1'b0); add_byte(1, 8'(8'hB0 + m), 1'b1);
      add_byte(2, 8'(8'hC0 + m), 1'b0); add_byte(2, 8'(8'hD0 + m), 1'b1);
    end
    build_expected();
    drive();
    run_drain(500);

    // Single-byte messages on every port, held continuously valid.
    pen = 4'b0101; podd = 4'b0001;
    for (int m = 0; m < 3; m++)
      for (int p = 0; p < N; p++) add_byte(p, 8'(16 * m + p), 1'b1);
    build_expected();
    drive();
    run_drain(600);

    // Port 3 stalls after one byte; port 0 waits behind it.
    pen[3] = 1'b1; podd[3] = 1'b1;
    add_byte(3, 8'h55, 1'b0);
    exp_q.push_back('{port: 2'd3, cfg: {pen[3], podd[3]}, data: 8'h55});
    drive();
    wait_bytes(bytes_seen + 1, 100);
    add_byte(0, 8'h30, 1'b1);
    drive();
    for (int s = 1; s <= TO; s++) begin
      step();
      check($sformatf("timeout_pulse_stall%0d", s), tp_seen, s == TO);
    end
    check("timeout_port", timeout_port, 3);
    step();
    check("grant_after_timeout", grant, 4'b0001);
    exp_q.push_back('{port: 2'd0, cfg: {pen[0], podd[0]}, data: 8'h30});
    run_drain(200);
    m_last = 0;

    // Asynchronous reset in the middle of a port 2 message.
    pen[2] = 1'b1; podd[2] = 1'b0;
    for (int i = 0; i < 4; i++) add_byte(2, 8'(8'hE0 + i), i == 3);
    build_expected();
    drive();
    wait_bytes(bytes_seen + 1, 100);
    step();
    @(negedge clk);
    check("grant_before_reset", grant, 4'b0100);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_grant", grant, 0);
    check("async_rst_tx_in_valid", tx_in_valid, 0);
    check("async_rst_tx_in_data", tx_in_data, 0);
    check("async_rst_req_ready", req_ready, 0);
    check("async_rst_parity", {tx_parity_en, tx_parity_odd}, 0);
    check("async_rst_timeout_port", timeout_port, 0);
    check("async_rst_timeout_pulse", timeout_pulse, 0);
    for (int p = 0; p < N; p++) begin
      pq[p].delete();
      gap[p] = 0;
    end
    exp_q.delete();
    sink_cnt = 0;
    m_last   = N - 1;
    drive();
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    prev_par  = {tx_parity_en, tx_parity_odd};
    prev_busy = 1'b0;
    add_byte(0, 8'h0A, 1'b1);
    add_byte(1, 8'h0B, 1'b1);
    build_expected();
    drive();
    step();
    check("grant_after_reset", grant, 4'b0001);
    run_drain(200);

    // Randomized rounds.
    for (int r = 0; r < 10; r++) begin
      for (int p = 0; p < N; p++) begin
        pen[p]  = 1'($urandom_range(0, 1));
        podd[p] = 1'($urandom_range(0, 1));
        nm = $urandom_range(0, 2);
        for (int m = 0; m < nm; m++) begin
          len = $urandom_range(1, 4);
          for (int i = 0; i < len; i++) add_byte(p, 8'($urandom), i == len - 1);
        end
      end
      build_expected();
      drive();
      run_drain(2000);
    end

    check("timeout_count", tp_count, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
